// File: rtl/fp32_square.sv
// Iterative IEEE-754 single-precision squarer: one shift-add pass over the
// 24-bit significand, then a single round/pack cycle. Result is always non-negative.
module fp32_square #(
    parameter int          MUL_ITERS = 24,
    parameter logic [31:0] QNAN      = 32'h7FC00001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic [1:0] {IDLE, MULT, ROUND, DONE} state_t;

    state_t      state;
    logic [23:0] mant;
    logic [7:0]  exp_a;
    logic        special;
    logic [31:0] special_res;
    logic [4:0]  counter;
    logic [47:0] acc;
    logic        unused_sign;

    // The sign of a square is always positive, so the operand sign is dropped.
    assign unused_sign = a[31];
    assign in_ready    = (state == IDLE);

    function automatic logic [31:0] pack(input logic [47:0] p, input logic [7:0] ea);
        logic signed [9:0] e;
        logic signed [9:0] base;
        logic signed [9:0] ef;
        logic [9:0]        s;
        logic [24:0]       v;
        logic [23:0]       shifted;
        logic [22:0]       frac;
        logic [23:0]       sum;
        logic              guard;
        logic              sticky;
        logic              inc;
        e = $signed({1'b0, ea, 1'b0}) - 10'sd127;
        if (p[47]) begin
            frac   = p[46:24];
            guard  = p[23];
            sticky = |p[22:0];
            e      = e + 10'sd1;
        end else begin
            frac   = p[45:23];
            guard  = p[22];
            sticky = |p[21:0];
        end
        base = e;
        if (e <= 10'sd0) begin
            // Denormalise: hidden bit enters the fraction, lost bits fold into sticky.
            s = 10'sd1 - e;
            v = {1'b1, frac, guard};
            if (s >= 10'd25) begin
                shifted = '0;
                sticky  = 1'b1;
            end else begin
                shifted = 24'(v >> s);
                sticky  = sticky | (|(v & ~(25'h1FFFFFF << s)));
            end
            frac  = shifted[23:1];
            guard = shifted[0];
            base  = 10'sd0;
        end
        inc = guard & (sticky | frac[0]);
        sum = {1'b0, frac} + {23'b0, inc};
        ef  = base + $signed({9'b0, sum[23]});
        if (ef >= 10'sd255)
            return 32'h7F800000;
        return {1'b0, ef[7:0], sum[22:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            counter   <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mant    <= {1'b1, a[22:0]};
                        exp_a   <= a[30:23];
                        counter <= '0;
                        acc     <= '0;
                        if (a[30:23] == 8'hFF) begin
                            special     <= 1'b1;
                            special_res <= (a[22:0] != 23'd0) ? QNAN : 32'h7F800000;
                        end else begin
                            // Zero and subnormal squares both round to +0.
                            special     <= (a[30:23] == 8'h00);
                            special_res <= '0;
                        end
                        state <= MULT;
                    end
                end
                MULT: begin
                    if (mant[counter])
                        acc <= acc + ({24'b0, mant} << counter);
                    counter <= counter + 5'd1;
                    if (counter == 5'(MUL_ITERS - 1))
                        state <= ROUND;
                end
                ROUND: begin
                    result    <= special ? special_res : pack(acc, exp_a);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/fp32_square.md
Name: fp32_square

Overview:
- Iterative single-precision floating-point squarer: result = a*a, always non-negative. It is the inverse operation of the pipelined square-root unit.
- Used by the verification and normalisation datapaths to re-square root outputs and to compute energy terms.
- Area-lean sequential design: one 24x24 shift-add multiply, one operation in flight, valid/ready handshake on both sides.

Parameters:
- MUL_ITERS, 24, multiply iterations (one per mantissa bit); not to be overridden.
- QNAN, 32'h7FC00001, canonical quiet-NaN pattern returned for NaN inputs.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- a  input  32  IEEE-754 single operand; sampled only on the accept edge.
- in_valid  input  1  operand valid.
- in_ready  output  1  block idle and able to accept; equals (state==IDLE), combinational from state.
- result  output  32  squared value; stable while out_valid=1.
- out_valid  output  1  result valid; registered.
- out_ready  input  1  consumer accepts result.

Behaviour:
- Reset (rst_n=0 at an edge), including mid-operation:
  - state=IDLE, out_valid=0, result=0, counter=0, accumulator=0.
  - Any in-flight operation is discarded.
- FSM states IDLE -> MULT -> ROUND -> DONE -> IDLE.
- IDLE:
  - On an edge with in_valid & in_ready, register a; go to MULT with counter=0.
  - The operand is classified at acceptance into special flag + special result, sign dropped:
    - NaN (exp=FF, mant!=0) -> QNAN.
    - +/-Inf -> 7F800000.
    - +/-0 -> 00000000.
    - Subnormal input -> 00000000. Its exact square is below 2^-149 and rounds to +0.
- MULT:
  - Exactly 24 cycles. Each edge conditionally adds (m << counter) into a 48-bit accumulator when m[counter]=1; counter increments.
  - m = {1, mant}. After the 24th edge, go to ROUND.
  - Special operands still traverse MULT; latency is fixed and independent of the operand.
- ROUND: one edge. Packs the result, sets out_valid=1, and moves to DONE. Packing rules:
  - Base biased exponent: e = 2*exp_a - 127, computed as a signed 10-bit value.
  - Normalisation when P[47]=1:
    - frac = P[46:24], guard = P[23], sticky = |P[22:0].
    - e += 1.
  - Normalisation when P[47]=0: frac = P[45:23], guard = P[22], sticky = |P[21:0].
  - Underflow, when e <= 0:
    - Right-shift {1,frac,guard} by (1-e). All shifted-out bits OR into sticky.
    - A shift of 26 or more gives 0 before rounding.
    - Exponent field = 0.
  - Rounding: round-to-nearest-even; increment when guard & (sticky | lsb).
    - A mantissa carry-out increments the exponent.
    - A carry-out from the subnormal range yields exp=1.
  - Overflow: if the final e >= 255, result = 7F800000.
  - Sign bit always 0.
  - Special flag set: the special result overrides all arithmetic.
- DONE:
  - result and out_valid are held until an edge with out_ready=1. On that edge out_valid=0 and state=IDLE.
  - in_ready=0 throughout, so a new operand is accepted no earlier than the edge after handoff.
- Latency: accept edge E0, result visible after E25 (25 cycles). Minimum initiation interval is 27 cycles with out_ready tied high.
- in_valid while busy is ignored and not queued. out_ready while out_valid=0 has no effect.

Test Plan:
- Reset mid-MULT (rst_n low one edge at E10):
  - Required: out_valid=0, in_ready=1 on the next cycle; no stale result ever appears.
  - Then 3F800000 -> 3F800000 after 25 cycles.
- Normal values, out_ready=1:
  - 40400000 (3.0) -> 41100000.
  - C0000000 (-2.0) -> 40800000.
  - 3FC00000 (1.5) -> 40100000.
  - Each with out_valid rising exactly 25 cycles after accept.
- Rounding and overflow:
  - 3F800001 -> 3F800002 (tie-free round-down of the 2^-46 term).
  - 5F800000 (2^64) -> 7F800000.
  - 7F7FFFFF -> 7F800000.
- Underflow:
  - 1C800000 (2^-70) -> 00000200.
  - 00000001 (subnormal) -> 00000000.
  - 1A000000 (2^-75) -> 00000000.
- Specials:
  - 7FC00000 -> 7FC00001.
  - FF800000 -> 7F800000.
  - 80000000 -> 00000000.
  - All with fixed 25-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - Required: result stable and in_ready=0 while in_valid pulses.
  - Release: one-cycle handoff, then in_ready=1 the following cycle and the next operand is accepted correctly.
